// File: rtl/cpu_bus_master.sv
// cpu_bus_master - initiator side of the CPU memory bus.
//
// Accepts one load/store at a time from the CPU pipeline, drives it onto the
// bus (address/wdata/WLEN/EN_N), waits for READY from the responder and
// returns a one-cycle response with sign/zero-extended load data. Misaligned
// accesses, the reserved size code and bus timeouts return an error response.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake (ready == master idle)
//   req_we/size/signed         access kind: store/load, byte/half/word, sign
//   req_addr/req_wdata         byte address, low-justified store data
//   resp_valid/rdata/err       one-cycle response pulse, data, error flag
//   address/wdata/WLEN/EN_N    bus request (EN_N active low)
//   READY/rdata                bus responder completion and read data
`timescale 1ns/1ps

module cpu_bus_master #(
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [31:0] wdata,
  output logic [1:0]  WLEN,
  output logic        EN_N,
  input  logic        READY,
  input  logic [31:0] rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_BUSY    = 2'b01,
    S_ERR     = 2'b10,
    S_RECOVER = 2'b11
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_address, w_address_nxt;
  logic [31:0]        r_wdata, w_wdata_nxt;
  logic [1:0]         r_wlen, w_wlen_nxt;
  logic               r_en_n, w_en_n_nxt;
  logic               r_resp_valid, w_resp_valid_nxt;
  logic [31:0]        r_resp_rdata, w_resp_rdata_nxt;
  logic               r_resp_err, w_resp_err_nxt;
  logic [CNT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic [1:0]         r_size, w_size_nxt;
  logic               r_signed, w_signed_nxt;
  logic               r_we, w_we_nxt;
  logic               w_ready_ok;
  logic               w_timeout;

  // Load data extension by access size.
  function automatic logic [31:0] extend_load(input logic [1:0] size,
                                              input logic sgn,
                                              input logic [31:0] d);
    logic [31:0] v;
    case (size)
      2'b00:   v = sgn ? {{24{d[7]}}, d[7:0]}   : {24'h000000, d[7:0]};
      2'b01:   v = sgn ? {{16{d[15]}}, d[15:0]} : {16'h0000, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  // Reserved size code or an address not aligned to the access size.
  function automatic logic bad_request(input logic [1:0] size,
                                       input logic [1:0] lsb);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lsb[0];
      2'b10:   bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign address    = r_address;
  assign wdata      = r_wdata;
  assign WLEN       = r_wlen;
  assign EN_N       = r_en_n;

  // READY from the responder is registered on its side, so it may still be
  // high from the previous transfer; it only counts after MIN_WAIT cycles.
  assign w_ready_ok = READY && (r_wait_cnt >= CNT_W'(MIN_WAIT));
  assign w_timeout  = (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_address_nxt    = r_address;
    w_wdata_nxt      = r_wdata;
    w_wlen_nxt       = r_wlen;
    w_en_n_nxt       = r_en_n;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_size_nxt       = r_size;
    w_signed_nxt     = r_signed;
    w_we_nxt         = r_we;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (bad_request(req_size, req_addr[1:0])) begin
            w_state_nxt      = S_ERR;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
            w_resp_rdata_nxt = 32'h0000_0000;
          end else begin
            w_state_nxt    = S_BUSY;
            w_address_nxt  = req_addr;
            w_wdata_nxt    = req_wdata;
            // Store WLEN codes are size+1 (01 byte, 10 half, 11 word).
            w_wlen_nxt     = req_we ? (req_size + 2'd1) : 2'b00;
            w_en_n_nxt     = 1'b0;
            w_wait_cnt_nxt = {CNT_W{1'b0}};
            w_size_nxt     = req_size;
            w_signed_nxt   = req_signed;
            w_we_nxt       = req_we;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_ready_ok) begin
          w_state_nxt      = S_RECOVER;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b0;
          w_resp_rdata_nxt = r_we ? 32'h0000_0000 : extend_load(r_size, r_signed, rdata);
          w_en_n_nxt       = 1'b1;
          w_wlen_nxt       = 2'b00;
        end else if (w_timeout) begin
          w_state_nxt      = S_RECOVER;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b1;
          w_resp_rdata_nxt = 32'h0000_0000;
          w_en_n_nxt       = 1'b1;
          w_wlen_nxt       = 2'b00;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_ERR:     w_state_nxt = S_IDLE;
      S_RECOVER: w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_en_n_nxt  = 1'b1;
        w_wlen_nxt  = 2'b00;
      end
    endcase
  end

  // State and registered outputs; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_address    <= 32'h0000_0000;
      r_wdata      <= 32'h0000_0000;
      r_wlen       <= 2'b00;
      r_en_n       <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_resp_err   <= 1'b0;
      r_wait_cnt   <= {CNT_W{1'b0}};
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_we         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_address    <= w_address_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wlen       <= w_wlen_nxt;
      r_en_n       <= w_en_n_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_size       <= w_size_nxt;
      r_signed     <= w_signed_nxt;
      r_we         <= w_we_nxt;
    end
  end

endmodule
